cv32e40p_parity_err_ctrl: RTL and testbench
===========================================

# cv32e40p_parity_err_ctrl

Recovery controller for a bank of `NUM_REGS` parity-protected pipeline registers in the cv32e40p fault-tolerance datapath. It collects the per-register `mem_err` flags and handles one faulty register at a time. For each one it halts the core, drives a one-hot reload select that steers the faulty register's data input to its golden source, and re-checks parity. It then releases the core and raises an interrupt, or declares a fatal error after repeated failures. It also keeps sticky error status and a saturating event counter for software.

## Interface
Parameters:
- `NUM_REGS`, 8: number of protected registers monitored; must be ≥2.
- `CNT_WIDTH`, 8: width of the handled-event counter.
- `RELOAD_CYCLES`, 2: cycles `reload_o` is held per attempt; must be ≥1.
- `MAX_RETRY`, 2: failed re-checks tolerated before FATAL; must be ≥1.
- `IDX_W` is derived as `$clog2(NUM_REGS)`; it is not user-set.

Ports (reset `rst_n` is asynchronous, active-low; clock is `clk`):
- `clk`, input, 1: clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `mem_err_i`, input, `NUM_REGS`: per-register parity error flags.
- `enable_i`, input, 1: allows new recovery sequences to start.
- `halt_ack_i`, input, 1: core acknowledges the halt.
- `irq_ack_i`, input, 1: software clears `irq_o`.
- `halt_req_o`, output, 1: halt request to the core.
- `reload_o`, output, `NUM_REGS`: one-hot reload select.
- `irq_o`, output, 1: level interrupt, "error recovered".
- `fatal_o`, output, 1: unrecoverable error, sticky.
- `busy_o`, output, 1: FSM is not in IDLE.
- `err_idx_o`, output, `IDX_W`: index of the last or current handled register.
- `err_sticky_o`, output, `NUM_REGS`: sticky OR of all errors ever seen.
- `err_cnt_o`, output, `CNT_WIDTH`: count of recovery sequences started, saturating.

## Operation
- **Reset values:** every output is 0. State is IDLE, `pending_q` is 0, the retry count is 0 and the RELOAD counter is 0.
- **Error capture:**
  - Every cycle, `pending_q <= pending_q | mem_err_i`.
  - Every cycle, `err_sticky_o <= err_sticky_o | mem_err_i`. Sticky bits clear only on reset.
  - Capture continues regardless of `enable_i` or the current state.
- **Clearing a pending bit:** in RELEASE, `pending_q[idx]` is cleared. If `mem_err_i[idx]` is 1 in that same cycle, the set wins.
- **Selection:** in IDLE with `enable_i=1` and `pending_q≠0`, the lowest set index of `pending_q` is latched into `idx`, which drives `err_idx_o`.
- **On leaving IDLE:** the FSM goes to HALT, `err_cnt_o` increments (saturating at all-ones) and the retry count is set to 0.
- **FSM states:**
  - **IDLE:** `busy_o=0`.
  - **HALT:** `halt_req_o=1`. Stays until `halt_ack_i=1`, then goes to RELOAD and loads the RELOAD counter with `RELOAD_CYCLES-1`.
  - **RELOAD:** `halt_req_o=1` and `reload_o = 1<<idx`. Goes to CHECK when the counter reaches 0; otherwise the counter decrements.
  - **CHECK** (one cycle): `halt_req_o=1`, `reload_o=0`.
    - If `mem_err_i[idx]=0`, go to RELEASE.
    - Otherwise increment the retry count. If it now equals `MAX_RETRY`, go to FATAL; else go back to RELOAD with the counter reloaded.
  - **RELEASE** (one cycle): `halt_req_o=0`. Sets `irq_o`, clears `pending_q[idx]`, then goes to IDLE.
  - **FATAL:** terminal until reset. `halt_req_o=1`, `fatal_o=1`, `reload_o=0`, `busy_o=1`.
- **Interrupt:** `irq_o` is a registered level. Set in RELEASE, cleared when `irq_ack_i=1`; if both happen in the same cycle, the set wins.
- **During a sequence:** errors on other registers only accumulate in `pending_q`. They are serviced in index order after returning to IDLE.
- **`enable_i`:** deasserting it mid-sequence does not abort the sequence. It only blocks the IDLE→HALT transition.
- **`halt_ack_i`:** ignored outside HALT.
- **Reset mid-sequence:** everything returns to reset values immediately. `reload_o` and `halt_req_o` drop asynchronously.

## Timing
- **Error to halt request:** `mem_err_i[k]` rising in cycle t gives `pending_q[k]=1` in cycle t+1, and HALT with `halt_req_o=1` in cycle t+2 (when `enable_i=1`).
- **Halt acknowledge to reload:** `halt_ack_i` in HALT cycle h gives `reload_o` high for cycles h+1 … h+`RELOAD_CYCLES`, then CHECK at h+`RELOAD_CYCLES`+1.
- **Re-check sampling:** the protected register captures the golden data on the last reload edge. Its `mem_err` output is therefore valid in the CHECK cycle.
- **Successful sequence:** from HALT entry it takes 1 (minimum) + `RELOAD_CYCLES` + 2 cycles back to IDLE. `irq_o` is high from the cycle after RELEASE.
- **Back-to-back errors:** the next pending register is selected in the first IDLE cycle after RELEASE. There is one idle cycle between sequences.
- **Output types:** all outputs are Moore, decoded from registered state or registered directly. There are no combinational input-to-output paths.

## Structure
- **Package `cv32e40p_parity_pkg`:**
  - the state enum `parity_ctrl_state_e` {IDLE, HALT, RELOAD, CHECK, RELEASE, FATAL};
  - a localparam default for `RELOAD_CYCLES`;
  - a `lowest_set_index` function, shared with future ECC controllers.
- **Sub-module `cv32e40p_prio_enc`:** parameterised lowest-index priority encoder. Outputs are `idx` and `valid`; it is combinational.
- **Top-level contents:** the FSM, counters and status registers live in the top module. Instances of the protected registers are outside this block.

## Test plan
- **Single error:** with `NUM_REGS=8`, pulse `mem_err_i=8'h10` for 1 cycle, with `halt_ack_i` returned 1 cycle after `halt_req_o`. Expect:
  - `reload_o=8'h10` for 2 cycles;
  - `irq_o=1`;
  - `err_idx_o=4`, `err_cnt_o=1`, `err_sticky_o=8'h10`;
  - `halt_req_o` high for exactly 5 cycles.
- **Simultaneous errors:** `mem_err_i=8'h24` in one cycle. Expect two sequences in order `idx=2` then `idx=5`, with `err_cnt_o=2`. Expect `irq_ack_i` between them to clear `irq_o` and RELEASE to set it again.
- **Persistent error:** hold `mem_err_i[3]=1`. Expect 2 RELOAD/CHECK rounds, then `fatal_o=1` and `halt_req_o` stuck at 1. Later errors on other bits update only the sticky bits.
- **Gating and collisions:**
  - `enable_i=0` while `mem_err_i=8'h01` pulses: expect no `halt_req_o`, with `pending_q` retained. Raising `enable_i` starts the sequence 1 cycle later.
  - `irq_ack_i` in the same cycle as RELEASE: expect `irq_o=1`.
- **Delayed acknowledge and reset:** hold `halt_ack_i` low for 10 cycles. Expect HALT held with `reload_o=0`. Assert `rst_n=0` during RELOAD: expect all outputs 0 immediately and `err_cnt_o=0` after reset.
- **Counter saturation:** with `CNT_WIDTH=2`, run 5 sequences. Expect `err_cnt_o` to stick at 3.

Source files
------------

// File: rtl/cv32e40p_parity_pkg.sv
// Shared types and helpers for the parity/ECC recovery controllers.
package cv32e40p_parity_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HALT    = 3'd1,
    RELOAD  = 3'd2,
    CHECK   = 3'd3,
    RELEASE = 3'd4,
    FATAL   = 3'd5
  } parity_ctrl_state_e;

  localparam int unsigned RELOAD_CYCLES_DEFAULT = 2;

  // Widest error vector the shared encoder function accepts.
  localparam int unsigned PRIO_MAX_W = 64;

  // Lowest set bit position of vec; 0 when vec is all zeros.
  function automatic logic [31:0] lowest_set_index(input logic [PRIO_MAX_W-1:0] vec);
    logic [31:0] idx;
    idx = '0;
    for (int i = PRIO_MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/cv32e40p_prio_enc.sv
// Combinational lowest-index-first priority encoder.
module cv32e40p_prio_enc
  import cv32e40p_parity_pkg::*;
#(
  parameter int unsigned N  = 8,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [PRIO_MAX_W-1:0] vec_ext;
  logic [31:0]           idx_full;

  assign vec_ext  = PRIO_MAX_W'(vec);
  assign idx_full = lowest_set_index(vec_ext);
  assign idx      = idx_full[IW-1:0];
  assign valid    = |vec;

endmodule

// File: rtl/cv32e40p_parity_err_ctrl.sv
// Recovery controller: halts the core, reloads one faulty parity-protected
// register from its golden source, re-checks it and reports the outcome.
module cv32e40p_parity_err_ctrl
  import cv32e40p_parity_pkg::*;
#(
  parameter int unsigned NUM_REGS      = 8,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter int unsigned RELOAD_CYCLES = RELOAD_CYCLES_DEFAULT,
  parameter int unsigned MAX_RETRY     = 2,
  localparam int unsigned IDX_W        = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REGS-1:0]  mem_err_i,
  input  logic                 enable_i,
  input  logic                 halt_ack_i,
  input  logic                 irq_ack_i,
  output logic                 halt_req_o,
  output logic [NUM_REGS-1:0]  reload_o,
  output logic                 irq_o,
  output logic                 fatal_o,
  output logic                 busy_o,
  output logic [IDX_W-1:0]     err_idx_o,
  output logic [NUM_REGS-1:0]  err_sticky_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam int unsigned CW = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [CW-1:0] RCNT_INIT   = CW'(RELOAD_CYCLES - 1);

  parity_ctrl_state_e   state_q;
  logic [NUM_REGS-1:0]  pending_q, pending_d;
  logic [NUM_REGS-1:0]  sel_onehot;
  logic [IDX_W-1:0]     idx_q;
  logic [RW-1:0]        retry_q;
  logic [CW-1:0]        rcnt_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [NUM_REGS-1:0]  sticky_q;
  logic                 irq_q;
  logic [IDX_W-1:0]     enc_idx;
  logic                 enc_valid;

  cv32e40p_prio_enc #(.N(NUM_REGS)) u_prio_enc (
    .vec   (pending_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign sel_onehot = NUM_REGS'(1) << idx_q;

  // A new error on the register being released must survive the clear.
  always_comb begin
    pending_d = pending_q;
    if (state_q == RELEASE) pending_d = pending_d & ~sel_onehot;
    pending_d = pending_d | mem_err_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      rcnt_q    <= '0;
      cnt_q     <= '0;
      sticky_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      sticky_q  <= sticky_q | mem_err_i;

      if (state_q == RELEASE) irq_q <= 1'b1;
      else if (irq_ack_i)     irq_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (enable_i && enc_valid) begin
            idx_q   <= enc_idx;
            retry_q <= '0;
            state_q <= HALT;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          end
        end
        HALT: begin
          if (halt_ack_i) begin
            rcnt_q  <= RCNT_INIT;
            state_q <= RELOAD;
          end
        end
        RELOAD: begin
          if (rcnt_q == '0) state_q <= CHECK;
          else              rcnt_q  <= rcnt_q - 1'b1;
        end
        CHECK: begin
          if (!mem_err_i[idx_q]) begin
            state_q <= RELEASE;
          end else begin
            retry_q <= retry_q + 1'b1;
            if (retry_q + 1'b1 == RETRY_LIMIT) begin
              state_q <= FATAL;
            end else begin
              rcnt_q  <= RCNT_INIT;
              state_q <= RELOAD;
            end
          end
        end
        RELEASE: state_q <= IDLE;
        FATAL:   state_q <= FATAL;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore outputs decoded from registered state only.
  assign halt_req_o   = (state_q == HALT) || (state_q == RELOAD) ||
                        (state_q == CHECK) || (state_q == FATAL);
  assign reload_o     = (state_q == RELOAD) ? sel_onehot : '0;
  assign fatal_o      = (state_q == FATAL);
  assign busy_o       = (state_q != IDLE);
  assign irq_o        = irq_q;
  assign err_idx_o    = idx_q;
  assign err_sticky_o = sticky_q;
  assign err_cnt_o    = cnt_q;

endmodule

// File: tb/tb_cv32e40p_parity_err_ctrl.sv
// Directed bench for the parity recovery controller, plus a narrow-counter
// instance sharing the same stimulus to observe saturation.
module tb_cv32e40p_parity_err_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mem_err = '0;
  logic       enable = 1'b0;
  logic       halt_ack = 1'b0;
  logic       irq_ack = 1'b0;

  logic       halt_req, irq, fatal, busy;
  logic [7:0] reload, sticky, cnt;
  logic [2:0] idx;

  logic       s_halt_req, s_irq, s_fatal, s_busy;
  logic [7:0] s_reload, s_sticky;
  logic [2:0] s_idx;
  logic [1:0] s_cnt;

  int checks = 0;
  int failures = 0;
  int halt_n = 0;
  int reload_n = 0;
  logic [7:0] reload_or = '0;

  // clock/reset
  always #5 clk = ~clk;

  cv32e40p_parity_err_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_err_i(mem_err), .enable_i(enable),
    .halt_ack_i(halt_ack), .irq_ack_i(irq_ack), .halt_req_o(halt_req),
    .reload_o(reload), .irq_o(irq), .fatal_o(fatal), .busy_o(busy),
    .err_idx_o(idx), .err_sticky_o(sticky), .err_cnt_o(cnt)
  );

  cv32e40p_parity_err_ctrl #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mem_err_i(mem_err), .enable_i(enable),
    .halt_ack_i(halt_ack), .irq_ack_i(irq_ack), .halt_req_o(s_halt_req),
    .reload_o(s_reload), .irq_o(s_irq), .fatal_o(s_fatal), .busy_o(s_busy),
    .err_idx_o(s_idx), .err_sticky_o(s_sticky), .err_cnt_o(s_cnt)
  );

  // Cycle monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (halt_req) halt_n = halt_n + 1;
    if (reload != 8'h00) begin
      reload_n  = reload_n + 1;
      reload_or = reload_or | reload;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    halt_n    = 0;
    reload_n  = 0;
    reload_or = '0;
  endtask

  task automatic wait_halt(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (halt_req) begin seen = 1'b1; break; end
      step();
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  task automatic handshake(input int delay);
    repeat (delay) step();
    halt_ack = 1'b1;
    step();
    halt_ack = 1'b0;
  endtask

  // Returns positioned in the RELEASE cycle (busy with halt dropped).
  task automatic wait_release(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (busy && !halt_req) begin seen = 1'b1; break; end
      step();
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  task automatic pulse_err(input logic [7:0] v);
    mem_err = v;
    step();
    mem_err = '0;
  endtask

  initial begin
    enable = 1'b1;
    #12;
    check_eq("rst_halt",   32'(halt_req), 32'd0);
    check_eq("rst_reload", 32'(reload),   32'd0);
    check_eq("rst_irq",    32'(irq),      32'd0);
    check_eq("rst_fatal",  32'(fatal),    32'd0);
    check_eq("rst_busy",   32'(busy),     32'd0);
    check_eq("rst_cnt",    32'(cnt),      32'd0);
    check_eq("rst_sticky", 32'(sticky),   32'd0);
    check_eq("rst_idx",    32'(idx),      32'd0);
    check_eq("rst_scnt",   32'(s_cnt),    32'd0);
    rst_n = 1'b1;
    step();

    // Single error on register 4.
    clear_mon();
    pulse_err(8'h10);
    step();
    check_eq("single_halt_t2", 32'(halt_req), 32'd1);
    wait_halt("single_wait_halt");
    handshake(1);
    wait_release("single_wait_release");
    step();
    check_eq("single_halt_cycles", 32'(halt_n),    32'd5);
    check_eq("single_reload_n",    32'(reload_n),  32'd2);
    check_eq("single_reload_sel",  32'(reload_or), 32'h10);
    check_eq("single_irq",         32'(irq),       32'd1);
    check_eq("single_idx",         32'(idx),       32'd4);
    check_eq("single_cnt",         32'(cnt),       32'd1);
    check_eq("single_sticky",      32'(sticky),    32'h10);
    check_eq("single_idle",        32'(busy),      32'd0);

    // Simultaneous errors on 2 and 5: serviced lowest first.
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check_eq("ack_clears_irq", 32'(irq), 32'd0);
    pulse_err(8'h24);
    step();
    check_eq("simul_first_idx", 32'(idx), 32'd2);
    wait_halt("simul_wait_halt1");
    handshake(0);
    wait_release("simul_wait_release1");
    step();
    check_eq("simul_irq1", 32'(irq), 32'd1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check_eq("simul_irq_acked", 32'(irq),      32'd0);
    check_eq("simul_second_halt", 32'(halt_req), 32'd1);
    check_eq("simul_second_idx", 32'(idx),      32'd5);
    handshake(0);
    wait_release("simul_wait_release2");
    step();
    check_eq("simul_irq2",   32'(irq),    32'd1);
    check_eq("simul_cnt",    32'(cnt),    32'd3);
    check_eq("simul_sticky", 32'(sticky), 32'h34);

    // Gating with enable low, then ack colliding with RELEASE.
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    enable = 1'b0;
    pulse_err(8'h01);
    clear_mon();
    repeat (5) step();
    check_eq("gate_no_halt", 32'(halt_n), 32'd0);
    check_eq("gate_idle",    32'(busy),   32'd0);
    enable = 1'b1;
    step();
    check_eq("gate_start_halt", 32'(halt_req), 32'd1);
    check_eq("gate_start_idx",  32'(idx),      32'd0);
    irq_ack = 1'b1;
    handshake(0);
    wait_release("collide_wait_release");
    check_eq("collide_irq_low_in_release", 32'(irq), 32'd0);
    step();
    irq_ack = 1'b0;
    check_eq("collide_set_wins", 32'(irq), 32'd1);
    check_eq("collide_cnt",      32'(cnt), 32'd4);

    // Delayed acknowledge, then reset during RELOAD.
    pulse_err(8'h02);
    step();
    clear_mon();
    repeat (10) step();
    check_eq("delay_halt_held", 32'(halt_n),   32'd10);
    check_eq("delay_no_reload", 32'(reload_n), 32'd0);
    check_eq("delay_halt_now",  32'(halt_req), 32'd1);
    halt_ack = 1'b1;
    step();
    halt_ack = 1'b0;
    check_eq("delay_reload_sel", 32'(reload), 32'h02);
    check_eq("cnt_five",         32'(cnt),    32'd5);
    check_eq("sat_cnt",          32'(s_cnt),  32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_reload", 32'(reload),   32'd0);
    check_eq("arst_halt",   32'(halt_req), 32'd0);
    check_eq("arst_busy",   32'(busy),     32'd0);
    check_eq("arst_irq",    32'(irq),      32'd0);
    check_eq("arst_sticky", 32'(sticky),   32'd0);
    check_eq("arst_cnt",    32'(cnt),      32'd0);
    check_eq("arst_scnt",   32'(s_cnt),    32'd0);
    #1 rst_n = 1'b1;
    step();
    check_eq("post_rst_cnt",  32'(cnt),  32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    // Persistent error on register 3 ends in FATAL.
    mem_err = 8'h08;
    step();
    step();
    clear_mon();
    wait_halt("persist_wait_halt");
    handshake(0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (fatal) begin seen = 1'b1; break; end
        step();
      end
      check_eq("persist_reach_fatal", 32'(seen), 32'd1);
    end
    check_eq("persist_reload_n", 32'(reload_n), 32'd4);
    check_eq("persist_reload0",  32'(reload),   32'd0);
    check_eq("persist_halt",     32'(halt_req), 32'd1);
    check_eq("persist_busy",     32'(busy),     32'd1);
    check_eq("persist_idx",      32'(idx),      32'd3);
    mem_err = 8'h48;
    step();
    mem_err = '0;
    repeat (5) step();
    check_eq("fatal_sticky",  32'(sticky),   32'h48);
    check_eq("fatal_cnt",     32'(cnt),      32'd1);
    check_eq("fatal_idx",     32'(idx),      32'd3);
    check_eq("fatal_stuck",   32'(fatal),    32'd1);
    check_eq("fatal_halt",    32'(halt_req), 32'd1);
    check_eq("fatal_no_irq",  32'(irq),      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
